// File: rtl/data_inf_pkg.sv
// Shared definitions for the data_inf stream bridges.
//   skid_state_e : occupancy state of a two-entry skid buffer
//   SKID_DEPTH   : number of storage entries in a skid buffer
//   skid_occ()   : maps a skid state to its entry count
package data_inf_pkg;

    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_occ(input skid_state_e s);
        case (s)
            ONE:     skid_occ = 2'd1;
            FULL:    skid_occ = 2'(SKID_DEPTH);
            default: skid_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_inf_a2b_skid.sv
// Registered bridge from a plain data_inf stream (slaver_*) to a clocked
// data_inf_c stream (master_*), built as a two-entry skid buffer so that
// slaver_ready, master_valid and master_data all come from flops and one
// beat per clock is sustained.
// Ports:
//   clock, rst            : single clock, synchronous active-high reset
//   slaver_valid/_data    : upstream beat (in)
//   slaver_ready          : upstream accept (out, registered)
//   master_clock/_rst_n   : clock and active-low reset forwarded downstream
//   master_valid/_data    : downstream beat (out, registered)
//   master_ready          : downstream accept (in)
//   occupancy             : entries held, 0..2 (debug)
module data_inf_a2b_skid #(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             slaver_valid,
    input  logic [DSIZE-1:0] slaver_data,
    output logic             slaver_ready,
    output logic             master_clock,
    output logic             master_rst_n,
    output logic             master_valid,
    output logic [DSIZE-1:0] master_data,
    input  logic             master_ready,
    output logic [1:0]       occupancy
);
    import data_inf_pkg::*;

    skid_state_e      state_q, state_d;
    logic [DSIZE-1:0] m_data_q, m_data_d;
    logic [DSIZE-1:0] s_data_q, s_data_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_fire, out_fire;

    assign master_clock = clock;
    assign master_rst_n = ~rst;

    // ready_q resets to 1 (EMPTY accepts); the rst gate keeps the upstream
    // ready low while reset is held and lets it rise in the very first
    // cycle after rst drops.
    assign slaver_ready = ready_q & ~rst;
    assign master_valid = valid_q;
    assign master_data  = m_data_q;
    assign occupancy    = occ_q;

    assign in_fire  = slaver_valid & slaver_ready;
    assign out_fire = valid_q & master_ready;

    // State and data registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            occ_q    <= occ_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_d = FULL;
                else if (!in_fire && out_fire) state_d = EMPTY;
            end
            // slaver_ready is low in FULL, so only a drain can happen here
            FULL:    if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        case (state_q)
            EMPTY: if (in_fire) m_data_d = slaver_data;
            ONE: begin
                // New beat goes straight to the main register when the old
                // one leaves in the same cycle, otherwise it parks in skid.
                if (in_fire && out_fire) m_data_d = slaver_data;
                else if (in_fire)        s_data_d = slaver_data;
            end
            FULL:    if (out_fire) m_data_d = s_data_q;
            default: ;
        endcase
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
        occ_d   = skid_occ(state_d);
    end

endmodule

// File: tb/tb_data_inf_a2b_skid.sv
// Self-checking bench for data_inf_a2b_skid. Inputs are driven 1ns after
// the rising edge; a monitor samples on the falling edge and keeps a queue
// of accepted beats as the reference model: occupancy, valid and ready are
// derived from the queue length, output beats are popped and compared.
module tb_data_inf_a2b_skid;
    localparam int DSIZE = 8;

    logic             clock = 1'b0;
    logic             rst;
    logic             slaver_valid;
    logic [DSIZE-1:0] slaver_data;
    logic             slaver_ready;
    logic             master_clock;
    logic             master_rst_n;
    logic             master_valid;
    logic [DSIZE-1:0] master_data;
    logic             master_ready;
    logic [1:0]       occupancy;

    data_inf_a2b_skid #(.DSIZE(DSIZE)) dut (
        .clock        (clock),
        .rst          (rst),
        .slaver_valid (slaver_valid),
        .slaver_data  (slaver_data),
        .slaver_ready (slaver_ready),
        .master_clock (master_clock),
        .master_rst_n (master_rst_n),
        .master_valid (master_valid),
        .master_data  (master_data),
        .master_ready (master_ready),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model / monitor ----------------
    logic [DSIZE-1:0] sb[$];
    logic             rst_prev  = 1'b0;
    logic             hold_prev = 1'b0;
    logic [DSIZE-1:0] data_prev = '0;
    int               peak_occ  = 0;

    always @(negedge clock) begin
        if (rst) begin
            chk("rst_slaver_ready", {31'd0, slaver_ready}, 0);
            if (rst_prev) begin
                chk("rst_master_valid", {31'd0, master_valid}, 0);
                chk("rst_occupancy", {30'd0, occupancy}, 0);
            end
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            chk("occupancy", {30'd0, occupancy}, sb.size());
            chk("master_valid", {31'd0, master_valid}, (sb.size() != 0) ? 1 : 0);
            chk("slaver_ready", {31'd0, slaver_ready}, (sb.size() < 2) ? 1 : 0);
            if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
            if (hold_prev) begin
                chk("stable_valid", {31'd0, master_valid}, 1);
                chk("stable_data", {24'd0, master_data}, {24'd0, data_prev});
            end
            if (master_valid && master_ready) begin
                if (sb.size() == 0) chk("unexpected_beat", {24'd0, master_data}, 32'hFFFF_FFFF);
                else chk("out_data", {24'd0, master_data}, {24'd0, sb.pop_front()});
            end
            if (slaver_valid && slaver_ready) sb.push_back(slaver_data);
            hold_prev = master_valid & ~master_ready;
            data_prev = master_data;
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    // Present one beat and wait (bounded) until it is accepted; returns
    // 1ns after the accepting edge with valid still asserted.
    task automatic send(input logic [DSIZE-1:0] d);
        int tries = 0;
        slaver_valid = 1'b1;
        slaver_data  = d;
        forever begin
            @(negedge clock);
            if (slaver_ready) break;
            tries++;
            if (tries > 100) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        slaver_valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        int accepted;
        int cyc;
        rst          = 1'b1;
        slaver_valid = 1'b0;
        slaver_data  = '0;
        master_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", {31'd0, slaver_ready}, 1);
        @(posedge clock); #1;

        // streaming 0x01..0x10 with downstream always ready
        master_ready = 1'b1;
        peak_occ = 0;
        for (int i = 1; i <= 16; i++) send(DSIZE'(i));
        idle(3);
        chk("stream_peak_le1", (peak_occ <= 1) ? 1 : 0, 1);
        chk("stream_drained", sb.size(), 0);

        // backpressure fill
        master_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        slaver_valid = 1'b1;
        slaver_data  = 8'hA3;
        @(negedge clock);
        chk("bp_ready_low", {31'd0, slaver_ready}, 0);
        chk("bp_occ_full", {30'd0, occupancy}, 2);
        chk("bp_head", {24'd0, master_data}, 32'hA1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("bp_a3_held", {30'd0, occupancy}, 2);
        @(posedge clock); #1;
        master_ready = 1'b1;
        send(8'hA3);
        idle(4);
        chk("bp_drained", sb.size(), 0);

        // simultaneous in/out in ONE
        master_ready = 1'b0;
        send(8'h55);
        slaver_valid = 1'b1;
        slaver_data  = 8'h66;
        master_ready = 1'b1;
        @(posedge clock); #1;
        slaver_valid = 1'b0;
        master_ready = 1'b0;
        @(negedge clock);
        chk("simul_data", {24'd0, master_data}, 32'h66);
        chk("simul_occ", {30'd0, occupancy}, 1);
        @(posedge clock); #1;
        master_ready = 1'b1;
        idle(2);

        // reset while FULL
        master_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        slaver_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_full", {30'd0, occupancy}, 2);
        @(posedge clock); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        rst = 1'b0;
        master_ready = 1'b1;
        @(negedge clock);
        chk("rst_release_ready", {31'd0, slaver_ready}, 1);
        chk("rst_release_valid", {31'd0, master_valid}, 0);
        @(posedge clock); #1;
        idle(5);

        // random traffic, 1000 accepted beats
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            slaver_valid = 1'($urandom_range(0, 1));
            slaver_data  = DSIZE'($urandom);
            master_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (slaver_valid && slaver_ready) accepted++;
            @(posedge clock); #1;
            cyc++;
        end
        chk("rand_accepted", accepted, 1000);

        // drain with a bound
        slaver_valid = 1'b0;
        master_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        @(negedge clock);
        chk("final_drained", sb.size(), 0);
        chk("final_occ", {30'd0, occupancy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
